// File: rtl/rc4_pkg.sv
// RC4 sequencer shared definitions.
// State encoding and S-box sizing constants.
package rc4_pkg;

  localparam int SBOX_SIZE   = 256;
  localparam int INIT_CYCLES = SBOX_SIZE;
  localparam int KSA_CYCLES  = 2 * SBOX_SIZE;
  localparam int KEY_MAX_DEF = 32;
  localparam int LEN_W_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_KSA_RD,
    S_KSA_SW,
    S_P_RD,
    S_P_SW,
    S_P_OUT
  } rc4_state_e;

endpackage

// File: rtl/rc4_kidx_ctr.sv
// Key index counter for the KSA.
// Wraps at key_len-1 by compare, so no divider is needed.
module rc4_kidx_ctr
  import rc4_pkg::*;
#(
  parameter int KW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [8:0]    key_len,
  output logic [KW-1:0] kidx
);

  logic [KW-1:0] kidx_q, kidx_d;
  logic          wrap;

  assign wrap = ({{(9-KW){1'b0}}, kidx_q}
                 == (key_len - 9'd1));
  assign kidx = kidx_q;

  always_comb begin
    kidx_d = kidx_q;
    if (clr) begin
      kidx_d = '0;
    end else if (inc) begin
      kidx_d = wrap ? '0 : kidx_q + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) kidx_q <= '0;
    else        kidx_q <= kidx_d;
  end

endmodule

// File: rtl/rc4_ctrl.sv
// RC4 S-box sequencer: INIT, KSA, then PRGA
// keystream over a valid/ready port.
module rc4_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_MAX = KEY_MAX_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [8:0]                 key_len,
  input  logic [LEN_W-1:0]           num_bytes,
  output logic [$clog2(KEY_MAX)-1:0] key_addr,
  input  logic [7:0]                 key_byte,
  output logic [7:0]                 ram_raddr_1,
  input  logic [7:0]                 ram_rdata_1,
  output logic [7:0]                 ram_waddr_2,
  output logic [7:0]                 ram_wdata_2,
  output logic [7:0]                 ram_addr_3,
  output logic [7:0]                 ram_wdata_3,
  input  logic [7:0]                 ram_rdata_3,
  output logic                       ram_wen,
  output logic [7:0]                 ks_data,
  output logic                       ks_valid,
  input  logic                       ks_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int         KW    = $clog2(KEY_MAX);
  localparam logic [8:0] KMAX9 = 9'(KEY_MAX);

  rc4_state_e       state_q, state_d;
  logic [7:0]       i_q, i_d;
  logic [7:0]       j_q, j_d;
  logic [7:0]       t_q, t_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] nbytes_q, nbytes_d;
  logic [8:0]       klen_q, klen_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             kidx_clr, kidx_inc;
  logic [KW-1:0]    kidx;
  logic             bad_cfg;

  rc4_kidx_ctr #(.KW(KW)) u_kidx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (kidx_clr),
    .inc     (kidx_inc),
    .key_len (klen_q),
    .kidx    (kidx)
  );

  assign bad_cfg = (key_len == 9'd0)
                || (key_len > KMAX9)
                || (num_bytes == '0);

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    t_d         = t_q;
    count_d     = count_q;
    nbytes_d    = nbytes_q;
    klen_d      = klen_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    kidx_clr    = 1'b0;
    kidx_inc    = 1'b0;
    key_addr    = '0;
    ram_raddr_1 = '0;
    ram_waddr_2 = '0;
    ram_wdata_2 = '0;
    ram_addr_3  = '0;
    ram_wdata_3 = '0;
    ram_wen     = 1'b0;
    ks_data     = '0;
    ks_valid    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_cfg) begin
            cfg_err_d = 1'b1;
          end else begin
            klen_d   = key_len;
            nbytes_d = num_bytes;
            count_d  = '0;
            i_d      = '0;
            state_d  = S_INIT;
          end
        end
      end
      S_INIT: begin
        ram_wen     = 1'b1;
        ram_waddr_2 = i_q;
        ram_addr_3  = i_q;
        ram_wdata_2 = i_q;
        ram_wdata_3 = i_q;
        i_d         = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          j_d      = '0;
          kidx_clr = 1'b1;
          state_d  = S_KSA_RD;
        end
      end
      S_KSA_RD: begin
        ram_raddr_1 = i_q;
        key_addr    = kidx;
        j_d         = j_q + ram_rdata_1 + key_byte;
        state_d     = S_KSA_SW;
      end
      S_KSA_SW: begin
        ram_raddr_1 = i_q;
        ram_addr_3  = j_q;
        ram_wen     = 1'b1;
        ram_waddr_2 = i_q;
        ram_wdata_2 = ram_rdata_3;
        ram_wdata_3 = ram_rdata_1;
        kidx_inc    = 1'b1;
        i_d         = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          j_d     = '0;
          state_d = S_P_RD;
        end else begin
          state_d = S_KSA_RD;
        end
      end
      S_P_RD: begin
        ram_raddr_1 = i_q + 8'd1;
        i_d         = i_q + 8'd1;
        j_d         = j_q + ram_rdata_1;
        state_d     = S_P_SW;
      end
      S_P_SW: begin
        ram_raddr_1 = i_q;
        ram_addr_3  = j_q;
        ram_wen     = 1'b1;
        ram_waddr_2 = i_q;
        ram_wdata_2 = ram_rdata_3;
        ram_wdata_3 = ram_rdata_1;
        t_d         = ram_rdata_1 + ram_rdata_3;
        state_d     = S_P_OUT;
      end
      S_P_OUT: begin
        // S is not written here, so S[t] is stable
        // for the whole stall and needs no holding reg.
        ram_raddr_1 = t_q;
        ks_valid    = 1'b1;
        ks_data     = ram_rdata_1;
        if (ks_ready) begin
          count_d = count_q + LEN_W'(1);
          if (count_d == nbytes_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_P_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      t_q       <= '0;
      count_q   <= '0;
      nbytes_q  <= '0;
      klen_q    <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      t_q       <= t_d;
      count_q   <= count_d;
      nbytes_q  <= nbytes_d;
      klen_q    <= klen_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_rc4_ctrl.sv
// Self-checking bench for rc4_ctrl with an S-box
// RAM model, key store and an array-based RC4 model.
module tb_rc4_ctrl;

  localparam int KEY_MAX = 32;
  localparam int LEN_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [8:0]       key_len = '0;
  logic [LEN_W-1:0] num_bytes = '0;
  logic [4:0]       key_addr;
  logic [7:0]       key_byte;
  logic [7:0]       ram_raddr_1, ram_rdata_1;
  logic [7:0]       ram_waddr_2, ram_wdata_2;
  logic [7:0]       ram_addr_3, ram_wdata_3;
  logic [7:0]       ram_rdata_3;
  logic             ram_wen;
  logic [7:0]       ks_data;
  logic             ks_valid;
  logic             ks_ready = 1'b1;
  logic             busy, done, cfg_err;

  logic [7:0] mem [256];
  logic [7:0] key_mem [KEY_MAX];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rc4_ctrl #(.KEY_MAX(KEY_MAX), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_len     (key_len),
    .num_bytes   (num_bytes),
    .key_addr    (key_addr),
    .key_byte    (key_byte),
    .ram_raddr_1 (ram_raddr_1),
    .ram_rdata_1 (ram_rdata_1),
    .ram_waddr_2 (ram_waddr_2),
    .ram_wdata_2 (ram_wdata_2),
    .ram_addr_3  (ram_addr_3),
    .ram_wdata_3 (ram_wdata_3),
    .ram_rdata_3 (ram_rdata_3),
    .ram_wen     (ram_wen),
    .ks_data     (ks_data),
    .ks_valid    (ks_valid),
    .ks_ready    (ks_ready),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  assign key_byte    = key_mem[key_addr];
  assign ram_rdata_1 = mem[ram_raddr_1];
  assign ram_rdata_3 = mem[ram_addr_3];

  // port 3 written last so it wins on equal addresses
  always @(posedge clk) begin
    if (ram_wen) begin
      mem[ram_waddr_2] <= ram_wdata_2;
      mem[ram_addr_3]  <= ram_wdata_3;
    end
  end

  function automatic void rc4_ref(int klen, int n);
    int s [256];
    int i, j, tmp;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + s[k] + int'(key_mem[k % klen])) % 256;
      tmp = s[k]; s[k] = s[j]; s[j] = tmp;
    end
    exp_q.delete();
    i = 0; j = 0;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      exp_q.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endfunction

  task automatic set_key(input logic [47:0] k,
                         input int len);
    for (int b = 0; b < len; b++)
      key_mem[b] = k[8*(len-1-b) +: 8];
  endtask

  task automatic run_job(input int klen, input int n,
                         input bit rnd, input bit chk_lat,
                         input bit poke, input string nm);
    int cyc, lat, dones, budget;
    logic [7:0] prev_d;
    bit prev_stall;
    rc4_ref(klen, n);
    got_q.delete();
    @(negedge clk);
    key_len = 9'(klen);
    num_bytes = LEN_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; lat = -1; dones = 0; prev_stall = 1'b0;
    budget = 771 + n * 40 + 50;
    vecs++;
    if (busy !== 1'b1 || cfg_err !== 1'b0) begin
      errs++;
      $display("FAIL %s accept busy=%b cfg_err=%b want 1,0",
               nm, busy, cfg_err);
    end
    while (got_q.size() < n && cyc < budget) begin
      ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && (cyc == 10 || cyc == 772)) begin
        start = 1'b1;
        key_len = 9'd5;
        num_bytes = LEN_W'(2);
      end else begin
        start = 1'b0;
      end
      if (prev_stall) begin
        vecs++;
        if (ks_valid !== 1'b1 || ks_data !== prev_d) begin
          errs++;
          $display("FAIL %s stall_hold v=%b d=%h want 1 %h",
                   nm, ks_valid, ks_data, prev_d);
        end
      end
      if (ks_valid === 1'b1 && lat < 0) lat = cyc;
      if (done === 1'b1) dones++;
      if (ks_valid === 1'b1 && ks_ready) begin
        vecs++;
        if (ks_data !== exp_q[got_q.size()]) begin
          errs++;
          $display("FAIL %s byte%0d got %h want %h", nm,
                   got_q.size(), ks_data, exp_q[got_q.size()]);
        end
        got_q.push_back(ks_data);
      end
      prev_stall = (ks_valid === 1'b1) && !ks_ready;
      prev_d = ks_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ks_ready = 1'b1;
    vecs++;
    if (got_q.size() != n) begin
      errs++;
      $display("FAIL %s timeout got %0d bytes want %0d",
               nm, got_q.size(), n);
    end
    vecs++;
    if (done !== 1'b1 || busy !== 1'b0 || dones != 0) begin
      errs++;
      $display("FAIL %s done done=%b busy=%b early=%0d want 1,0,0",
               nm, done, busy, dones);
    end
    if (chk_lat) begin
      vecs++;
      if (lat != 771) begin
        errs++;
        $display("FAIL %s latency got %0d want 771", nm, lat);
      end
    end
    @(negedge clk);
    vecs++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL %s done_pulse got %b want 0", nm, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({busy, done, cfg_err, ks_valid, ks_data, ram_wen,
         key_addr, ram_raddr_1, ram_waddr_2, ram_wdata_2,
         ram_addr_3, ram_wdata_3} !== '0) begin
      errs++;
      $display("FAIL reset_outputs busy=%b v=%b wen=%b want 0",
               busy, ks_valid, ram_wen);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_key;
    logic [79:0] want;
    want = 80'hEB9F7781B734CA72A719;
    set_key(48'h4B6579, 3);
    run_job(3, 10, 1'b0, 1'b1, 1'b0, "key");
    for (int b = 0; b < got_q.size(); b++) begin
      vecs++;
      if (got_q[b] !== want[8*(9-b) +: 8]) begin
        errs++;
        $display("FAIL key_vec%0d got %h want %h",
                 b, got_q[b], want[8*(9-b) +: 8]);
      end
    end
  endtask

  task automatic test_wiki_stall;
    logic [47:0] want;
    want = 48'h6044DB6D41B7;
    set_key(48'h57696B69, 4);
    run_job(4, 6, 1'b1, 1'b0, 1'b0, "wiki");
    for (int b = 0; b < got_q.size(); b++) begin
      vecs++;
      if (got_q[b] !== want[8*(5-b) +: 8]) begin
        errs++;
        $display("FAIL wiki_vec%0d got %h want %h",
                 b, got_q[b], want[8*(5-b) +: 8]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] w1;
    logic [23:0] w2;
    w1 = 64'h04D46B053CA87B59;
    w2 = 24'hEB9F77;
    set_key(48'h536563726574, 6);
    run_job(6, 8, 1'b0, 1'b0, 1'b0, "secret");
    for (int b = 0; b < got_q.size(); b++) begin
      vecs++;
      if (got_q[b] !== w1[8*(7-b) +: 8]) begin
        errs++;
        $display("FAIL secret_vec%0d got %h want %h",
                 b, got_q[b], w1[8*(7-b) +: 8]);
      end
    end
    set_key(48'h4B6579, 3);
    run_job(3, 3, 1'b0, 1'b0, 1'b0, "b2b_key");
    for (int b = 0; b < got_q.size(); b++) begin
      vecs++;
      if (got_q[b] !== w2[8*(2-b) +: 8]) begin
        errs++;
        $display("FAIL b2b_vec%0d got %h want %h",
                 b, got_q[b], w2[8*(2-b) +: 8]);
      end
    end
  endtask

  task automatic test_cfg_err;
    int kl [3];
    int nb [3];
    kl[0] = 0;           nb[0] = 5;
    kl[1] = KEY_MAX + 1; nb[1] = 5;
    kl[2] = 3;           nb[2] = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      key_len = 9'(kl[c]);
      num_bytes = LEN_W'(nb[c]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vecs++;
      if (cfg_err !== 1'b1 || busy !== 1'b0
          || ram_wen !== 1'b0) begin
        errs++;
        $display("FAIL cfg_err%0d err=%b busy=%b wen=%b want 1,0,0",
                 c, cfg_err, busy, ram_wen);
      end
      @(negedge clk);
      vecs++;
      if (cfg_err !== 1'b0 || busy !== 1'b0
          || ram_wen !== 1'b0) begin
        errs++;
        $display("FAIL cfg_pulse%0d err=%b busy=%b wen=%b want 0,0,0",
                 c, cfg_err, busy, ram_wen);
      end
    end
  endtask

  task automatic test_reset_midswap;
    logic [23:0] want;
    want = 24'hEB9F77;
    set_key(48'h4B6579, 3);
    @(negedge clk);
    key_len = 9'd3;
    num_bytes = LEN_W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    vecs++;
    if (ram_wen !== 1'b1 || ram_raddr_1 !== 8'd21) begin
      errs++;
      $display("FAIL midswap_pos wen=%b i=%h want 1 15",
               ram_wen, ram_raddr_1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vecs++;
    if ({busy, done, cfg_err, ks_valid, ks_data, ram_wen,
         key_addr, ram_raddr_1, ram_waddr_2,
         ram_addr_3} !== '0) begin
      errs++;
      $display("FAIL midswap_reset busy=%b wen=%b done=%b want 0",
               busy, ram_wen, done);
    end
    rst_n = 1'b1;
    run_job(3, 3, 1'b0, 1'b0, 1'b0, "post_rst");
    for (int b = 0; b < got_q.size(); b++) begin
      vecs++;
      if (got_q[b] !== want[8*(2-b) +: 8]) begin
        errs++;
        $display("FAIL post_rst_vec%0d got %h want %h",
                 b, got_q[b], want[8*(2-b) +: 8]);
      end
    end
  endtask

  task automatic test_busy_start;
    logic [79:0] want;
    want = 80'hEB9F7781B734CA72A719;
    set_key(48'h4B6579, 3);
    run_job(3, 10, 1'b0, 1'b1, 1'b1, "poke");
    for (int b = 0; b < got_q.size(); b++) begin
      vecs++;
      if (got_q[b] !== want[8*(9-b) +: 8]) begin
        errs++;
        $display("FAIL poke_vec%0d got %h want %h",
                 b, got_q[b], want[8*(9-b) +: 8]);
      end
    end
  endtask

  task automatic test_random;
    int kl, n;
    for (int r = 0; r < 4; r++) begin
      kl = (r == 0) ? KEY_MAX
         : (r == 1) ? 1 : $urandom_range(2, KEY_MAX);
      n = (r == 1) ? 1 : $urandom_range(2, 12);
      for (int b = 0; b < KEY_MAX; b++)
        key_mem[b] = 8'($urandom);
      run_job(kl, n, 1'b1, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_key();
    test_wiki_stall();
    test_back_to_back();
    test_cfg_err();
    test_reset_midswap();
    test_busy_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
